// File: rtl/agcclip_pkg.sv
// Shared constants for the multi-channel AGC / transmit clipper: register map,
// reset defaults, field positions and a saturating counter helper.
package agcclip_pkg;

    localparam logic [2:0] REG_AGC  = 3'd0;
    localparam logic [2:0] REG_CLIP = 3'd1;
    localparam logic [2:0] REG_DIV  = 3'd2;
    localparam logic [2:0] REG_MODE = 3'd3;
    localparam logic [2:0] RD_STAT  = 3'd4;
    localparam logic [2:0] RD_CLIP  = 3'd5;

    localparam logic [15:0] AGC_DEFAULT  = 16'hF400;
    localparam logic [14:0] CLIP_DEFAULT = 15'h7FFF;
    localparam int          DIV_DEFAULT  = 21;
    localparam logic        EN_DEFAULT   = 1'b1;
    localparam logic [2:0]  CHSEL_DEFAULT = 3'd0;

    localparam int AGC_M_LSB   = 12;
    localparam int AGC_M_W     = 4;
    localparam int AGC_H_W     = 12;
    localparam int CLIP_L_W    = 15;
    localparam int MODE_EN_BIT = 15;
    localparam int MODE_SEL_W  = 3;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/agcclip_mc_agc_chan.sv
// One receive channel: shift-based block-floating gain with saturation,
// plus the attack / hang / release loop that steers the shift.
module agc_chan
    import agcclip_pkg::*;
#(
    parameter int IW = 20,
    parameter int OW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          riv,
    input  logic          agc_en,
    input  logic [3:0]    max_shift,
    input  logic [11:0]   hang_len,
    input  logic          sticky_clr,
    input  logic [IW-1:0] dix,
    input  logic [IW-1:0] diy,
    output logic [OW-1:0] dox,
    output logic [OW-1:0] doy,
    output logic [3:0]    shift,
    output logic          ovf_sticky
);

    localparam int EW = IW + 15;
    localparam int SR = IW - OW;

    localparam logic signed [EW-1:0] POS_MAX  = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [EW-1:0] NEG_MAX  = -POS_MAX;
    localparam logic signed [EW-1:0] NEG_MIN  = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    localparam logic signed [EW-1:0] HIGH_POS = {{(EW-OW+1){1'b0}}, 1'b1, {(OW-2){1'b0}}};
    localparam logic signed [EW-1:0] HIGH_NEG = -HIGH_POS;

    logic [OW-1:0] dox_q, dox_d, doy_q, doy_d;
    logic [3:0]    shift_q, shift_d;
    logic [11:0]   hang_q, hang_d;
    logic          sticky_q, sticky_d;

    logic signed [EW-1:0] cand_x, cand_y;
    logic                 ovf, high;

    // The IW+15 extension holds any 15-bit left shift without loss.
    function automatic logic signed [EW-1:0] cand_of(input logic [IW-1:0] x,
                                                      input logic [3:0]    s);
        logic signed [EW-1:0] e;
        e = {{15{x[IW-1]}}, x};
        e = e <<< s;
        return e >>> SR;
    endfunction

    function automatic logic [OW-1:0] sat_of(input logic signed [EW-1:0] c);
        logic signed [EW-1:0] r;
        if (c > POS_MAX)      r = POS_MAX;
        else if (c < NEG_MAX) r = NEG_MAX;
        else                  r = c;
        return r[OW-1:0];
    endfunction

    always_comb begin
        cand_x   = cand_of(dix, shift_q);
        cand_y   = cand_of(diy, shift_q);
        ovf      = (cand_x > POS_MAX) || (cand_x < NEG_MIN) ||
                   (cand_y > POS_MAX) || (cand_y < NEG_MIN);
        high     = (cand_x >= HIGH_POS) || (cand_x <= HIGH_NEG) ||
                   (cand_y >= HIGH_POS) || (cand_y <= HIGH_NEG);
        dox_d    = dox_q;
        doy_d    = doy_q;
        shift_d  = shift_q;
        hang_d   = hang_q;
        sticky_d = sticky_q & ~sticky_clr;

        if (riv) begin
            dox_d = sat_of(cand_x);
            doy_d = sat_of(cand_y);
            if (ovf) begin
                sticky_d = 1'b1;
                hang_d   = hang_len;
                if (shift_q != 4'd0) shift_d = shift_q - 4'd1;
            end else if (high) begin
                hang_d = hang_len;
            end else if (hang_q == 12'd0) begin
                hang_d = hang_len;
                if (shift_q < max_shift) shift_d = shift_q + 4'd1;
            end else begin
                hang_d = hang_q - 12'd1;
            end
        end

        // A lowered ceiling pulls the shift down even between samples.
        if (!agc_en) begin
            shift_d = max_shift;
            hang_d  = hang_len;
        end else if (shift_d > max_shift) begin
            shift_d = max_shift;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dox_q    <= '0;
            doy_q    <= '0;
            shift_q  <= '0;
            hang_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            dox_q    <= dox_d;
            doy_q    <= doy_d;
            shift_q  <= shift_d;
            hang_q   <= hang_d;
            sticky_q <= sticky_d;
        end
    end

    assign dox        = dox_q;
    assign doy        = doy_q;
    assign shift      = shift_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: rtl/agcclip_mc.sv
// Multi-channel receive AGC and transmit clipper with register file,
// clip-event counter, transmit-strobe divider and registered read mux.
module agcclip_mc
    import agcclip_pkg::*;
#(
    parameter int IW  = 20,
    parameter int OW  = 16,
    parameter int NCH = 2,
    parameter int DW  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*IW-1:0] rdix,
    input  logic [NCH*IW-1:0] rdiy,
    input  logic              riv,
    output logic [NCH*OW-1:0] rdox,
    output logic [NCH*OW-1:0] rdoy,
    output logic              rov,
    input  logic [OW-1:0]     tdix,
    input  logic [OW-1:0]     tdiy,
    input  logic              tiv,
    output logic [OW-1:0]     tdox,
    output logic [OW-1:0]     tdoy,
    output logic              tov,
    input  logic              toe,
    output logic              tie,
    input  logic              iocs,
    input  logic              iowr,
    input  logic              iord,
    input  logic [2:0]        ioaddr,
    input  logic [15:0]       din,
    output logic [15:0]       dout
);

    // riv and tiv are valid-only strobes: there is no ready, and a sample is
    // consumed on every cycle its valid is high; rov/tov follow one cycle later.

    localparam int CW = ((OW > 16) ? OW : 16) + 1;

    logic [15:0]          agc_q, agc_d;
    logic [CLIP_L_W-1:0]  clip_q, clip_d;
    logic [DW-1:0]        div_q, div_d;
    logic                 en_q, en_d;
    logic [MODE_SEL_W-1:0] chsel_q, chsel_d;

    logic [DW-1:0] cnt_q, cnt_d;
    logic [15:0]   clipcnt_q, clipcnt_d;
    logic [15:0]   dout_q, dout_d;
    logic          rov_q, tov_q;
    logic [OW-1:0] tdox_q, tdox_d, tdoy_q, tdoy_d;

    logic          wr, rd_stat, rd_clip, tie_c;
    logic [2:0]    sel;
    logic [3:0]    stat_shift;
    logic          stat_sticky;
    logic [15:0]   rd_val;

    logic signed [CW-1:0] tx_e, ty_e, lim, neg_lim, lx, ly;
    logic                 clip_x, clip_y;

    logic [3:0] shift_arr  [NCH];
    logic       sticky_arr [NCH];
    logic [NCH-1:0] sticky_clr;

    assign wr      = iocs & iowr;
    assign rd_stat = iord && (ioaddr == RD_STAT);
    assign rd_clip = iord && (ioaddr == RD_CLIP);
    assign sel     = (32'(chsel_q) < NCH) ? chsel_q : 3'd0;

    always_comb begin
        agc_d   = agc_q;
        clip_d  = clip_q;
        div_d   = div_q;
        en_d    = en_q;
        chsel_d = chsel_q;
        if (wr) begin
            case (ioaddr)
                REG_AGC:  agc_d  = din;
                REG_CLIP: clip_d = din[CLIP_L_W-1:0];
                REG_DIV:  div_d  = din[DW-1:0];
                REG_MODE: begin
                    en_d    = din[MODE_EN_BIT];
                    chsel_d = din[MODE_SEL_W-1:0];
                end
                default: ;
            endcase
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        assign sticky_clr[c] = rd_stat && (sel == 3'(c));

        agc_chan #(.IW(IW), .OW(OW)) u_chan (
            .clk        (clk),
            .rst        (rst),
            .riv        (riv),
            .agc_en     (en_q),
            .max_shift  (agc_q[AGC_M_LSB +: AGC_M_W]),
            .hang_len   (agc_q[AGC_H_W-1:0]),
            .sticky_clr (sticky_clr[c]),
            .dix        (rdix[c*IW +: IW]),
            .diy        (rdiy[c*IW +: IW]),
            .dox        (rdox[c*OW +: OW]),
            .doy        (rdoy[c*OW +: OW]),
            .shift      (shift_arr[c]),
            .ovf_sticky (sticky_arr[c])
        );
    end

    // Clipper: both axes compared in a width that holds -L without overflow.
    always_comb begin
        tx_e    = CW'($signed(tdix));
        ty_e    = CW'($signed(tdiy));
        lim     = $signed(CW'({1'b0, clip_q}));
        neg_lim = -lim;
        clip_x  = (tx_e > lim) || (tx_e < neg_lim);
        clip_y  = (ty_e > lim) || (ty_e < neg_lim);
        lx      = (tx_e > lim) ? lim : ((tx_e < neg_lim) ? neg_lim : tx_e);
        ly      = (ty_e > lim) ? lim : ((ty_e < neg_lim) ? neg_lim : ty_e);
        tdox_d  = tiv ? lx[OW-1:0] : tdox_q;
        tdoy_d  = tiv ? ly[OW-1:0] : tdoy_q;

        clipcnt_d = clipcnt_q;
        if (tiv && (clip_x || clip_y)) clipcnt_d = sat_inc16(clipcnt_q);
        if (rd_clip) clipcnt_d = (tiv && (clip_x || clip_y)) ? 16'd1 : 16'd0;
    end

    always_comb begin
        tie_c = toe && (cnt_q == div_q);
        cnt_d = cnt_q;
        if (toe) cnt_d = tie_c ? '0 : cnt_q + 1'b1;
        if (wr && (ioaddr == REG_DIV)) cnt_d = '0;
    end

    always_comb begin
        stat_shift  = '0;
        stat_sticky = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (sel == 3'(c)) begin
                stat_shift  = shift_arr[c];
                stat_sticky = sticky_arr[c];
            end
        end
        case (ioaddr)
            REG_AGC:  rd_val = agc_q;
            REG_CLIP: rd_val = 16'({1'b0, clip_q});
            REG_DIV:  rd_val = 16'(div_q);
            REG_MODE: rd_val = {en_q, 12'b0, chsel_q};
            RD_STAT:  rd_val = {stat_sticky, 11'b0, stat_shift};
            RD_CLIP:  rd_val = clipcnt_q;
            default:  rd_val = 16'd0;
        endcase
        dout_d = iord ? rd_val : dout_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            agc_q     <= AGC_DEFAULT;
            clip_q    <= CLIP_DEFAULT;
            div_q     <= DW'(DIV_DEFAULT);
            en_q      <= EN_DEFAULT;
            chsel_q   <= CHSEL_DEFAULT;
            cnt_q     <= '0;
            clipcnt_q <= '0;
            dout_q    <= '0;
            rov_q     <= 1'b0;
            tov_q     <= 1'b0;
            tdox_q    <= '0;
            tdoy_q    <= '0;
        end else begin
            agc_q     <= agc_d;
            clip_q    <= clip_d;
            div_q     <= div_d;
            en_q      <= en_d;
            chsel_q   <= chsel_d;
            cnt_q     <= cnt_d;
            clipcnt_q <= clipcnt_d;
            dout_q    <= dout_d;
            rov_q     <= riv;
            tov_q     <= tiv;
            tdox_q    <= tdox_d;
            tdoy_q    <= tdoy_d;
        end
    end

    assign rov  = rov_q;
    assign tov  = tov_q;
    assign tdox = tdox_q;
    assign tdoy = tdoy_q;
    assign tie  = tie_c;
    assign dout = dout_q;

endmodule

// File: tb/tb_agcclip_mc.sv
// Directed bench for agcclip_mc: register readback table, divider timing,
// AGC ramp/attack/fixed-gain sequences and a clipper vector table.
module tb_agcclip_mc;

    localparam int IW  = 20;
    localparam int OW  = 16;
    localparam int NCH = 2;
    localparam int DW  = 8;

    logic              clk, rst;
    logic [NCH*IW-1:0] rdix, rdiy;
    logic              riv;
    logic [NCH*OW-1:0] rdox, rdoy;
    logic              rov;
    logic [OW-1:0]     tdix, tdiy, tdox, tdoy;
    logic              tiv, tov, toe, tie;
    logic              iocs, iowr, iord;
    logic [2:0]        ioaddr;
    logic [15:0]       din, dout;

    agcclip_mc #(.IW(IW), .OW(OW), .NCH(NCH), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .rdix(rdix), .rdiy(rdiy), .riv(riv),
        .rdox(rdox), .rdoy(rdoy), .rov(rov),
        .tdix(tdix), .tdiy(tdiy), .tiv(tiv),
        .tdox(tdox), .tdoy(tdoy), .tov(tov),
        .toe(toe), .tie(tie),
        .iocs(iocs), .iowr(iowr), .iord(iord),
        .ioaddr(ioaddr), .din(din), .dout(dout)
    );

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] ex;
        logic [15:0] ey;
        logic        clip;
    } clip_vec_t;

    int n_err    = 0;
    int n_checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [2:0] a, input logic [15:0] d);
        iocs = 1'b1; iowr = 1'b1; ioaddr = a; din = d;
        tick();
        iocs = 1'b0; iowr = 1'b0;
    endtask

    task automatic io_read(input logic [2:0] a, output logic [15:0] d);
        ioaddr = a; iord = 1'b1;
        tick();
        d = dout;
        iord = 1'b0;
    endtask

    task automatic rx(input int n);
        riv = 1'b1;
        repeat (n) tick();
        riv = 1'b0;
    endtask

    task automatic wait_tie(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!tie && n < 200);
    endtask

    rd_vec_t   rd_tab[8];
    clip_vec_t clip_tab[6];
    logic [15:0] rd;
    int          n;
    int          exp_cnt;

    initial begin
        rd_tab[0] = '{3'd0, 16'hF400};
        rd_tab[1] = '{3'd1, 16'h7FFF};
        rd_tab[2] = '{3'd2, 16'h0015};
        rd_tab[3] = '{3'd3, 16'h8000};
        rd_tab[4] = '{3'd4, 16'h0000};
        rd_tab[5] = '{3'd5, 16'h0000};
        rd_tab[6] = '{3'd6, 16'h0000};
        rd_tab[7] = '{3'd7, 16'h0000};

        clip_tab[0] = '{16'h2000, 16'hE000, 16'h1000, 16'hF000, 1'b1};
        clip_tab[1] = '{16'h0800, 16'hF800, 16'h0800, 16'hF800, 1'b0};
        clip_tab[2] = '{16'h1000, 16'hF000, 16'h1000, 16'hF000, 1'b0};
        clip_tab[3] = '{16'h7FFF, 16'h0000, 16'h1000, 16'h0000, 1'b1};
        clip_tab[4] = '{16'h8000, 16'h0FFF, 16'hF000, 16'h0FFF, 1'b1};
        clip_tab[5] = '{16'h0FFF, 16'hEFFF, 16'h0FFF, 16'hF000, 1'b1};

        rst = 1'b0;
        rdix = '0; rdiy = '0; riv = 1'b0;
        tdix = '0; tdiy = '0; tiv = 1'b0; toe = 1'b0;
        iocs = 1'b0; iowr = 1'b0; iord = 1'b0; ioaddr = '0; din = '0;

        // Reset state
        #3;
        check("rst_rov", 32'(rov), 32'd0);
        check("rst_tov", 32'(tov), 32'd0);
        check("rst_tie", 32'(tie), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_rdox", 32'(rdox), 32'd0);
        check("rst_rdoy", 32'(rdoy), 32'd0);
        check("rst_tdox", 32'(tdox), 32'd0);
        check("rst_tdoy", 32'(tdoy), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Register defaults and unused addresses
        for (int i = 0; i < 8; i++) begin
            io_read(rd_tab[i].addr, rd);
            check($sformatf("rd_default_a%0d", rd_tab[i].addr), 32'(rd), 32'(rd_tab[i].exp));
        end

        // Divider: default D=21 gives a 22-cycle period
        toe = 1'b1;
        wait_tie(n);
        check("div_sync", 32'(n < 200), 32'd1);
        wait_tie(n);
        check("div_period_1", n, 22);
        wait_tie(n);
        check("div_period_2", n, 22);
        n = 0;
        repeat (3) begin tick(); n++; end
        toe = 1'b0;
        repeat (5) begin tick(); n++; end
        toe = 1'b1;
        do begin tick(); n++; end while (!tie && n < 200);
        check("div_stretch", n, 27);
        io_write(3'd2, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            check("div_d0_tie", 32'(tie), 32'd1);
            tick();
        end
        toe = 1'b0;
        #1;
        check("div_toe_low", 32'(tie), 32'd0);
        io_read(3'd2, rd);
        check("rd_div", 32'(rd), 32'h0000);

        // AGC ramp: ch0 x=0x100, ch1 x=0, H=4, M=15
        io_write(3'd0, 16'hF004);
        rdix = {20'h00000, 20'h00100};
        rdiy = '0;
        rx(1);
        check("agc_rov", 32'(rov), 32'd1);
        check("agc_first", 32'(rdox[15:0]), 32'h0010);
        tick();
        check("agc_rov_idle", 32'(rov), 32'd0);
        check("agc_hold", 32'(rdox[15:0]), 32'h0010);
        io_read(3'd4, rd);
        check("shift_n1", 32'(rd), 32'h0001);
        rx(4);
        io_read(3'd4, rd);
        check("shift_n5", 32'(rd), 32'h0001);
        rx(1);
        io_read(3'd4, rd);
        check("shift_n6", 32'(rd), 32'h0002);
        rx(40);
        io_read(3'd4, rd);
        check("shift_n46", 32'(rd), 32'h000A);
        rx(14);
        io_read(3'd4, rd);
        check("shift_n60", 32'(rd), 32'h000A);
        check("agc_high_out", 32'(rdox[15:0]), 32'h4000);

        // Attack: full-scale input drops the shift one step per sample
        rdix = {20'h00000, 20'h7FFFF};
        riv = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("agc_sat", 32'(rdox[15:0]), 32'h7FFF);
        end
        riv = 1'b0;
        io_read(3'd4, rd);
        check("stat_sticky", 32'(rd), 32'h8000);
        io_read(3'd4, rd);
        check("stat_cleared", 32'(rd), 32'h0000);
        io_write(3'd3, 16'h8001);
        io_read(3'd4, rd);
        check("stat_ch1", 32'(rd), 32'h000E);
        io_write(3'd3, 16'h8005);
        io_read(3'd4, rd);
        check("stat_sel_oob", 32'(rd), 32'h0000);

        // Fixed gain: agc_en=0, M=3
        io_write(3'd3, 16'h0000);
        io_write(3'd0, 16'h3004);
        tick();
        rdix = {20'h00800, 20'h00400};
        rdiy = {20'h80000, 20'hFFC00};
        riv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fix_ch0_x", 32'(rdox[15:0]), 32'h0200);
            check("fix_ch0_y", 32'(rdoy[15:0]), 32'hFE00);
            check("fix_ch1_x", 32'(rdox[31:16]), 32'h0400);
            check("fix_ch1_y", 32'(rdoy[31:16]), 32'h8001);
        end
        riv = 1'b0;
        io_read(3'd4, rd);
        check("fix_stat_ch0", 32'(rd), 32'h0003);
        io_write(3'd3, 16'h0001);
        io_read(3'd4, rd);
        check("fix_stat_ch1", 32'(rd), 32'h8003);

        // Clipper at L=0x1000
        io_write(3'd1, 16'h1000);
        tdix = 16'h2000; tdiy = 16'hE000; tiv = 1'b1;
        tick();
        tiv = 1'b0;
        check("clip_tov", 32'(tov), 32'd1);
        check("clip_x", 32'(tdox), 32'h1000);
        check("clip_y", 32'(tdoy), 32'hF000);
        tick();
        check("clip_tov_idle", 32'(tov), 32'd0);
        check("clip_hold", 32'(tdox), 32'h1000);
        io_read(3'd5, rd);
        check("clip_cnt_1", 32'(rd), 32'h0001);
        io_read(3'd5, rd);
        check("clip_cnt_clr", 32'(rd), 32'h0000);
        exp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tdix = clip_tab[i].x; tdiy = clip_tab[i].y; tiv = 1'b1;
            tick();
            tiv = 1'b0;
            check($sformatf("clip_tab%0d_x", i), 32'(tdox), 32'(clip_tab[i].ex));
            check($sformatf("clip_tab%0d_y", i), 32'(tdoy), 32'(clip_tab[i].ey));
            if (clip_tab[i].clip) exp_cnt++;
        end
        io_read(3'd5, rd);
        check("clip_tab_cnt", 32'(rd), 32'(exp_cnt));

        // Counter saturation, then read-clear coincident with a clip
        tdix = 16'h7FFF; tdiy = 16'h0000; tiv = 1'b1;
        repeat (69999) tick();
        io_read(3'd5, rd);
        tiv = 1'b0;
        check("clip_cnt_sat", 32'(rd), 32'hFFFF);
        io_read(3'd5, rd);
        check("clip_cnt_coincident", 32'(rd), 32'h0001);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
